// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 app-interface arbiters.
package ddr3_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBeat0,
    StWaitBeat1,
    StDeliver
  } arb_state_t;

  localparam logic [2:0]  RAM_CMD_READ = 3'b001;
  localparam logic [2:0]  RAM_CMD_NOP  = 3'b000;
  localparam int unsigned RAM_ADDR_W   = 27;
  localparam int unsigned BURST_W      = 128;
  localparam int unsigned BEAT_W       = 64;
  localparam logic [26:0] ALIGN_MASK   = 27'h7FFFFF8;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set req bit searching upward
// (with wrap) from last_gnt+1.
module rr_select #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_gnt,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    // Scan from farthest to nearest so the nearest requester is written last.
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      j = (32'(last_gnt) + k) % NUM_REQ;
      if (req[j]) begin
        any = 1'b1;
        idx = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/ddr3_read_arbiter.sv
// Round-robin read arbiter sharing one DDR3 app interface among NUM_REQ clients;
// issues one 128-bit burst at a time and routes the reassembled data back.
module ddr3_read_arbiter
  import ddr3_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*RAM_ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [BURST_W-1:0]            rsp_data,
  output logic                          err,
  output logic [RAM_ADDR_W-1:0]         ram_address,
  output logic [2:0]                    ram_cmd,
  output logic                          ram_en,
  input  logic                          ram_rdy,
  input  logic                          ram_rd_valid,
  input  logic                          ram_rd_data_end,
  input  logic [BEAT_W-1:0]             ram_rd_data
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  arb_state_t            state_q, state_d;
  logic [IdxW-1:0]       last_gnt_q, last_gnt_d;
  logic [IdxW-1:0]       cur_idx_q, cur_idx_d;
  logic [RAM_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BEAT_W-1:0]     buf_lo_q, buf_lo_d;
  logic [BURST_W-1:0]    rsp_data_q, rsp_data_d;

  logic                  sel_any;
  logic [IdxW-1:0]       sel_idx;
  logic [RAM_ADDR_W-1:0] sel_addr;
  logic                  timeout_hit;
  logic                  beat_last;

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req      (req),
    .last_gnt (last_gnt_q),
    .any      (sel_any),
    .idx      (sel_idx)
  );

  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IdxW'(i)) sel_addr = req_addr[i*RAM_ADDR_W +: RAM_ADDR_W];
    end
  end

  assign timeout_hit = (cnt_q == CntMax);
  assign beat_last   = ram_rd_valid && ram_rd_data_end;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_gnt_q <= IdxW'(NUM_REQ - 1);
      cur_idx_q  <= '0;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      buf_lo_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cur_idx_q  <= cur_idx_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      buf_lo_q   <= buf_lo_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cur_idx_d  = cur_idx_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    buf_lo_d   = buf_lo_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (sel_any) begin
          cur_idx_d  = sel_idx;
          cur_addr_d = sel_addr & ALIGN_MASK;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (ram_rdy) begin
          last_gnt_d = cur_idx_q;
          cnt_d      = '0;
          state_d    = StWaitBeat0;
        end
      end
      StWaitBeat0: begin
        if (ram_rd_valid) begin
          if (ram_rd_data_end) begin
            state_d = StIdle;
          end else begin
            buf_lo_d = ram_rd_data;
            state_d  = StWaitBeat1;
          end
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
        // Saturate so a first beat landing on the last cycle cannot wrap the window.
        if (!timeout_hit) cnt_d = cnt_q + 1'b1;
      end
      StWaitBeat1: begin
        if (beat_last) begin
          rsp_data_d = {ram_rd_data, buf_lo_q};
          state_d    = StDeliver;
        end else begin
          if (ram_rd_valid) buf_lo_d = ram_rd_data;
          if (timeout_hit) state_d = StIdle;
        end
        if (!timeout_hit) cnt_d = cnt_q + 1'b1;
      end
      StDeliver: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are forced low while reset is held, even before the clearing edge.
  always_comb begin
    gnt         = '0;
    rsp_valid   = '0;
    err         = 1'b0;
    ram_en      = 1'b0;
    ram_cmd     = RAM_CMD_NOP;
    ram_address = '0;
    rsp_data    = reset ? rsp_data_q : '0;
    if (reset) begin
      unique case (state_q)
        StIssue: begin
          ram_en      = 1'b1;
          ram_cmd     = RAM_CMD_READ;
          ram_address = cur_addr_q;
          if (ram_rdy) gnt[cur_idx_q] = 1'b1;
        end
        StWaitBeat0: err = beat_last || (!ram_rd_valid && timeout_hit);
        StWaitBeat1: err = !beat_last && timeout_hit;
        StDeliver:   rsp_valid[cur_idx_q] = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_read_arbiter.sv
// Directed + randomized bench for ddr3_read_arbiter; the bench plays the DDR3 controller.
module tb_ddr3_read_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*27-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [127:0]    rsp_data;
  logic            err;
  logic [26:0]     ram_address;
  logic [2:0]      ram_cmd;
  logic            ram_en;
  logic            ram_rdy;
  logic            ram_rd_valid;
  logic            ram_rd_data_end;
  logic [63:0]     ram_rd_data;

  int           tests = 0;
  int           failed = 0;
  int           last_gnt;
  logic [127:0] last_rsp;

  always #5 clk = ~clk;

  ddr3_read_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_addr        (req_addr),
    .gnt             (gnt),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .err             (err),
    .ram_address     (ram_address),
    .ram_cmd         (ram_cmd),
    .ram_en          (ram_en),
    .ram_rdy         (ram_rdy),
    .ram_rd_valid    (ram_rd_valid),
    .ram_rd_data_end (ram_rd_data_end),
    .ram_rd_data     (ram_rd_data)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Reference arbitration: nearest requester after the previous winner, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ":gnt"}, 128'(gnt), 128'(0));
    check({tag, ":rsp_valid"}, 128'(rsp_valid), 128'(0));
    check({tag, ":err"}, 128'(err), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check({tag, ":ram_en"}, 128'(ram_en), 128'(0));
    check({tag, ":ram_cmd"}, 128'(ram_cmd), 128'(0));
    check({tag, ":ram_address"}, 128'(ram_address), 128'(0));
    check({tag, ":rsp_data"}, rsp_data, 128'(0));
  endtask

  // Starts in IDLE; issues one request set and returns in WAIT_BEAT0 after the grant.
  task automatic issue(input string tag, input logic [N-1:0] reqv, input int rdy_dly,
                       output int idx);
    logic [26:0] ea;
    idx = pick(reqv, last_gnt);
    ea  = req_addr[idx*27 +: 27] & 27'h7FFFFF8;
    req = reqv;
    cyc();
    ram_rdy = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      settle();
      check({tag, ":hold_en"}, 128'(ram_en), 128'(1));
      check({tag, ":hold_cmd"}, 128'(ram_cmd), 128'(3'b001));
      check({tag, ":hold_addr"}, 128'(ram_address), 128'(ea));
      check({tag, ":hold_gnt"}, 128'(gnt), 128'(0));
      cyc();
    end
    ram_rdy = 1'b1;
    settle();
    check({tag, ":en"}, 128'(ram_en), 128'(1));
    check({tag, ":cmd"}, 128'(ram_cmd), 128'(3'b001));
    check({tag, ":addr"}, 128'(ram_address), 128'(ea));
    check({tag, ":gnt"}, 128'(gnt), 128'(onehot(idx)));
    last_gnt = idx;
    cyc();
    ram_rdy  = 1'b0;
    req      = '0;
  endtask

  task automatic do_burst(input string tag, input logic [N-1:0] reqv, input int rdy_dly,
                          input int lat, input int gap, input bit extra,
                          input logic [63:0] b0, input logic [63:0] b1);
    int          idx;
    logic [63:0] lo;
    issue(tag, reqv, rdy_dly, idx);
    for (int i = 0; i < lat; i++) begin
      settle();
      check({tag, ":wait_en"}, 128'(ram_en), 128'(0));
      check_quiet({tag, ":wait"});
      cyc();
    end
    ram_rd_valid = 1'b1; ram_rd_data_end = 1'b0; ram_rd_data = b0;
    lo = b0;
    settle();
    check({tag, ":beat0_err"}, 128'(err), 128'(0));
    cyc();
    if (extra) begin
      ram_rd_data = ~b0;
      lo = ~b0;
      settle();
      check({tag, ":extra_err"}, 128'(err), 128'(0));
      cyc();
    end
    ram_rd_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      settle();
      check_quiet({tag, ":gap"});
      cyc();
    end
    ram_rd_valid = 1'b1; ram_rd_data_end = 1'b1; ram_rd_data = b1;
    settle();
    check({tag, ":early_rsp"}, 128'(rsp_valid), 128'(0));
    cyc();
    ram_rd_valid = 1'b0; ram_rd_data_end = 1'b0;
    settle();
    check({tag, ":rsp_valid"}, 128'(rsp_valid), 128'(onehot(idx)));
    check({tag, ":rsp_data"}, rsp_data, {b1, lo});
    check({tag, ":dlv_err"}, 128'(err), 128'(0));
    last_rsp = {b1, lo};
    cyc();
    settle();
    check({tag, ":idle_rsp"}, 128'(rsp_valid), 128'(0));
    check({tag, ":rsp_hold"}, rsp_data, last_rsp);
  endtask

  initial begin
    int idx;
    logic [N-1:0] rv;
    reset = 1'b0; req = '0; req_addr = '0; ram_rdy = 1'b0;
    ram_rd_valid = 1'b0; ram_rd_data_end = 1'b0; ram_rd_data = '0;
    last_gnt = N - 1;
    last_rsp = '0;
    repeat (3) cyc();
    check_all_zero("reset");
    reset = 1'b1;
    cyc();

    // Single request, client 1, unaligned address.
    req_addr[27 +: 27] = 27'h0000013;
    do_burst("single", 4'b0010, 0, 1, 0, 1'b0, 64'h1111_1111_1111_1111,
             64'h2222_2222_2222_2222);

    // Controller stalls the command for 5 cycles.
    req_addr[2*27 +: 27] = 27'h1234567;
    do_burst("stall", 4'b0100, 5, 2, 1, 1'b0, 64'hA5A5_0000_1234_5678, 64'h0F0F_F0F0_DEAD_BEEF);

    // No data after acceptance.
    issue("tmo", 4'b1000, 0, idx);
    for (int i = 1; i < TO; i++) begin
      settle();
      check_quiet("tmo_wait");
      cyc();
    end
    settle();
    check("tmo_err", 128'(err), 128'(1));
    check("tmo_rsp", 128'(rsp_valid), 128'(0));
    cyc();
    ram_rd_valid = 1'b1; ram_rd_data_end = 1'b1; ram_rd_data = '1;
    settle();
    check_quiet("tmo_late");
    check("tmo_idle_en", 128'(ram_en), 128'(0));
    cyc();
    ram_rd_valid = 1'b0; ram_rd_data_end = 1'b0;
    do_burst("after_tmo", 4'b0001, 0, 3, 2, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);

    // First beat flagged as last.
    issue("order", 4'b0010, 1, idx);
    ram_rd_valid = 1'b1; ram_rd_data_end = 1'b1; ram_rd_data = 64'h5555_6666_7777_8888;
    settle();
    check("order_err", 128'(err), 128'(1));
    check("order_rsp", 128'(rsp_valid), 128'(0));
    cyc();
    ram_rd_valid = 1'b0; ram_rd_data_end = 1'b0;
    settle();
    check_quiet("order_after");
    check("order_data", rsp_data, last_rsp);

    // Reset asserted in WAIT_BEAT1.
    issue("rst", 4'b0100, 0, idx);
    ram_rd_valid = 1'b1; ram_rd_data_end = 1'b0; ram_rd_data = 64'h9999;
    cyc();
    ram_rd_valid = 1'b0;
    reset = 1'b0;
    settle();
    check_all_zero("rst_now");
    cyc();
    ram_rd_valid = 1'b1; ram_rd_data_end = 1'b1;
    settle();
    check_all_zero("rst_1");
    cyc();
    check_all_zero("rst_2");
    reset = 1'b1;
    last_gnt = N - 1;
    last_rsp = '0;
    settle();
    check_quiet("rst_stray");
    cyc();
    ram_rd_valid = 1'b0; ram_rd_data_end = 1'b0;
    settle();
    check_quiet("rst_stray2");

    // All clients requesting: strict rotation starting at client 0.
    for (int i = 0; i < N; i++) req_addr[i*27 +: 27] = 27'(32'h100 * (i + 1) + i);
    for (int b = 0; b < 8; b++) begin
      do_burst("rr", 4'b1111, 0, 1, 0, 1'b0, {32'(b), 32'hC0DE_0000},
               {32'hBEEF_0000, 32'(b)});
    end

    // Randomized traffic against the reference model.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) req_addr[i*27 +: 27] = 27'($urandom());
      rv = 4'($urandom_range(1, 15));
      do_burst("rand", rv, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               {$urandom(), $urandom()}, {$urandom(), $urandom()});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
